mips_multicycle_ctrl: RTL and testbench

Main control FSM that sequences the shared 32-bit MIPS datapath (PC, instruction/data memory, register file, sign extender, ALU, ALU control) over multiple cycles per instruction. It decodes opcode/funct latched in the IR and drives every mux select and write enable of the datapath. It stalls on a memory-ready handshake and traps on illegal opcodes. ALU function selection stays in the existing ALU control block, driven by this block's 3-bit alu_op.

---
 rtl/mips_ctrl_pkg.sv | 84 ++++++++
 rtl/mips_multicycle_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OP_W     = 6;
   localparam int unsigned ALU_OP_W = 3;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_WB_R     = 4'd7,
      S_EXEC_I   = 4'd8,
      S_WB_I     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL      = 4'd12,
      S_JR       = 4'd13,
      S_UNUSED   = 4'd14,
      S_TRAP     = 4'd15
   } state_t;

   // Opcode / funct values recognised by the decoder
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
   localparam logic [OP_W-1:0] FUNCT_JR = 6'b001000;

   // Codes sent to the ALU control block
   localparam logic [ALU_OP_W-1:0] ALU_ADD   = 3'd0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB   = 3'd1;
   localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 3'd2;
   localparam logic [ALU_OP_W-1:0] ALU_SLT   = 3'd3;

   // PC source mux
   localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [SEL_W-1:0] PC_SRC_REG_A  = 2'b11;

   // Register-file write address mux
   localparam logic [SEL_W-1:0] REG_DST_RT  = 2'b00;
   localparam logic [SEL_W-1:0] REG_DST_RD  = 2'b01;
   localparam logic [SEL_W-1:0] REG_DST_R31 = 2'b10;

   // Register-file write data mux
   localparam logic [SEL_W-1:0] MEM_TO_REG_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] MEM_TO_REG_MDR    = 2'b01;
   localparam logic [SEL_W-1:0] MEM_TO_REG_PC     = 2'b10;

   // ALU B operand mux
   localparam logic [SEL_W-1:0] ALU_B_REG     = 2'b00;
   localparam logic [SEL_W-1:0] ALU_B_FOUR    = 2'b01;
   localparam logic [SEL_W-1:0] ALU_B_IMM     = 2'b10;
   localparam logic [SEL_W-1:0] ALU_B_IMM_SH2 = 2'b11;

   // Dispatch target out of S_DECODE
   function automatic state_t decode_next(input logic [OP_W-1:0] op,
                                          input logic [OP_W-1:0] fn);
      state_t nxt;
      case (op)
         OP_RTYPE:      nxt = (fn == FUNCT_JR) ? S_JR : S_EXEC_R;
         OP_LW, OP_SW:  nxt = S_MEM_ADDR;
         OP_BEQ, OP_BNE: nxt = S_BRANCH;
         OP_ADDI, OP_SLTI: nxt = S_EXEC_I;
         OP_J:          nxt = S_JUMP;
         OP_JAL:        nxt = S_JAL;
         default:       nxt = S_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM sequencing the shared multicycle MIPS datapath.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter state_t RESET_STATE = S_FETCH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       branch_ne,
   output logic [1:0] pc_src,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       retire,
   output logic       illegal,
   output logic [3:0] state
);

   state_t state_q;
   state_t state_d;

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) state_q <= RESET_STATE;
      else       state_q <= state_d;
   end

   // Next-state logic; memory states wait for mem_ready, trap is sticky
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE:   state_d = decode_next(opcode, funct);
         S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WB:   state_d = S_FETCH;
         S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
         S_EXEC_R:   state_d = S_WB_R;
         S_WB_R:     state_d = S_FETCH;
         S_EXEC_I:   state_d = S_WB_I;
         S_WB_I:     state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_JAL:      state_d = S_FETCH;
         S_JR:       state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_TRAP;
      endcase
   end

   // Datapath control decode from current state; reset forces everything low
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      pc_src        = PC_SRC_ALU;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = REG_DST_RT;
      mem_to_reg    = MEM_TO_REG_ALUOUT;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ALU_B_REG;
      alu_op        = ALU_ADD;
      retire        = 1'b0;
      illegal       = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = ALU_B_FOUR;
               alu_op    = ALU_ADD;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b = ALU_B_IMM_SH2;
               alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = ALU_B_IMM;
               alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               reg_dst    = REG_DST_RT;
               mem_to_reg = MEM_TO_REG_MDR;
               reg_write  = 1'b1;
               retire     = 1'b1;
            end
            S_MEM_WR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
               retire    = mem_ready;
            end
            S_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_src_b = ALU_B_REG;
               alu_op    = ALU_FUNCT;
            end
            S_WB_R: begin
               reg_dst   = REG_DST_RD;
               reg_write = 1'b1;
               retire    = 1'b1;
            end
            S_EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = ALU_B_IMM;
               alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_WB_I: begin
               reg_dst   = REG_DST_RT;
               reg_write = 1'b1;
               retire    = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_src_b     = ALU_B_REG;
               alu_op        = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_src        = PC_SRC_ALUOUT;
               branch_ne     = (opcode == OP_BNE);
               retire        = 1'b1;
            end
            S_JUMP: begin
               pc_write = 1'b1;
               pc_src   = PC_SRC_JUMP;
               retire   = 1'b1;
            end
            S_JAL: begin
               // PC already holds PC+4 from fetch, so it is the link value
               pc_write   = 1'b1;
               pc_src     = PC_SRC_JUMP;
               reg_write  = 1'b1;
               reg_dst    = REG_DST_R31;
               mem_to_reg = MEM_TO_REG_PC;
               retire     = 1'b1;
            end
            S_JR: begin
               pc_write = 1'b1;
               pc_src   = PC_SRC_REG_A;
               retire   = 1'b1;
            end
            S_TRAP: begin
               illegal = 1'b1;
            end
            default: begin
               illegal = 1'b0;
            end
         endcase
      end
   end

   assign state = 4'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: a phase-level instruction model predicts every cycle's outputs.
module tb_mips_multicycle_ctrl;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       retire;
      logic       illegal;
      logic [3:0] state;
   } ov_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
   logic       ir_write, reg_write, alu_src_a, retire, illegal;
   logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
   logic [2:0] alu_op;
   logic [3:0] state;

   int  total = 0;
   int  bad = 0;
   int  exp_ret = 0;
   int  act_ret = 0;
   int  cyc_idx = 0;
   string tag = "reset";
   bit  mr_pat[64];
   ov_t exp_q[$];

   mips_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
      .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .retire(retire), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   function automatic ov_t blank(input int unsigned st);
      ov_t v = '0;
      v.state = 4'(st);
      return v;
   endfunction

   function automatic ov_t sample();
      ov_t v;
      v.pc_write = pc_write;   v.pc_write_cond = pc_write_cond; v.branch_ne = branch_ne;
      v.pc_src = pc_src;       v.i_or_d = i_or_d;               v.mem_read = mem_read;
      v.mem_write = mem_write; v.ir_write = ir_write;           v.reg_dst = reg_dst;
      v.mem_to_reg = mem_to_reg; v.reg_write = reg_write;       v.alu_src_a = alu_src_a;
      v.alu_src_b = alu_src_b; v.alu_op = alu_op;               v.retire = retire;
      v.illegal = illegal;     v.state = state;
      return v;
   endfunction

   // Reference model: expand one instruction into its per-cycle expected outputs
   task automatic build(input logic [5:0] op, input logic [5:0] fn,
                        input int reset_at, output int n);
      ov_t seq[$];
      ov_t v;
      bit  rdy;
      // fetch: repeats until memory answers
      do begin
         rdy = mr_pat[seq.size()];
         v = blank(0); v.mem_read = 1; v.alu_src_b = 2'b01;
         v.ir_write = rdy; v.pc_write = rdy;
         seq.push_back(v);
      end while (!rdy);
      v = blank(1); v.alu_src_b = 2'b11; seq.push_back(v);
      if (op == 6'b000000 && fn == 6'b001000) begin
         v = blank(13); v.pc_write = 1; v.pc_src = 2'b11; v.retire = 1; seq.push_back(v);
      end else if (op == 6'b000000) begin
         v = blank(6); v.alu_src_a = 1; v.alu_op = 3'd2; seq.push_back(v);
         v = blank(7); v.reg_dst = 2'b01; v.reg_write = 1; v.retire = 1; seq.push_back(v);
      end else if (op == 6'b100011) begin
         v = blank(2); v.alu_src_a = 1; v.alu_src_b = 2'b10; seq.push_back(v);
         do begin
            rdy = mr_pat[seq.size()];
            v = blank(3); v.mem_read = 1; v.i_or_d = 1; seq.push_back(v);
         end while (!rdy);
         v = blank(4); v.mem_to_reg = 2'b01; v.reg_write = 1; v.retire = 1; seq.push_back(v);
      end else if (op == 6'b101011) begin
         v = blank(2); v.alu_src_a = 1; v.alu_src_b = 2'b10; seq.push_back(v);
         do begin
            rdy = mr_pat[seq.size()];
            v = blank(5); v.mem_write = 1; v.i_or_d = 1; v.retire = rdy; seq.push_back(v);
         end while (!rdy);
      end else if (op == 6'b000100 || op == 6'b000101) begin
         v = blank(10); v.alu_src_a = 1; v.alu_op = 3'd1; v.pc_write_cond = 1;
         v.pc_src = 2'b01; v.branch_ne = (op == 6'b000101); v.retire = 1; seq.push_back(v);
      end else if (op == 6'b001000 || op == 6'b001010) begin
         v = blank(8); v.alu_src_a = 1; v.alu_src_b = 2'b10;
         v.alu_op = (op == 6'b001010) ? 3'd3 : 3'd0; seq.push_back(v);
         v = blank(9); v.reg_write = 1; v.retire = 1; seq.push_back(v);
      end else if (op == 6'b000010) begin
         v = blank(11); v.pc_write = 1; v.pc_src = 2'b10; v.retire = 1; seq.push_back(v);
      end else if (op == 6'b000011) begin
         v = blank(12); v.pc_write = 1; v.pc_src = 2'b10; v.reg_write = 1;
         v.reg_dst = 2'b10; v.mem_to_reg = 2'b10; v.retire = 1; seq.push_back(v);
      end else begin
         for (int i = 0; i < 20; i++) begin
            v = blank(15); v.illegal = 1; seq.push_back(v);
         end
      end
      // a reset cycle shows the current state with every control low
      if (reset_at >= 0 && reset_at < seq.size()) begin
         v = blank(int'(seq[reset_at].state));
         while (seq.size() > reset_at) void'(seq.pop_back());
         seq.push_back(v);
      end
      foreach (seq[i]) begin
         if (seq[i].retire) exp_ret++;
         exp_q.push_back(seq[i]);
      end
      n = seq.size();
   endtask

   task automatic run_instr(input string name, input logic [5:0] op,
                            input logic [5:0] fn, input int reset_at);
      int n;
      tag = name;
      build(op, fn, reset_at, n);
      opcode = op;
      funct  = fn;
      for (int c = 0; c < n; c++) begin
         mem_ready = mr_pat[c];
         reset     = (c == reset_at);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   task automatic ready_all();
      for (int i = 0; i < 64; i++) mr_pat[i] = 1'b1;
   endtask

   task automatic ready_rand();
      for (int i = 0; i < 64; i++) mr_pat[i] = (i >= 24) ? 1'b1 : ($urandom_range(0, 9) < 7);
   endtask

   // Monitor: every cycle pop one expected output vector and compare
   initial begin
      ov_t a;
      ov_t e;
      forever begin
         @(negedge clk);
         if (retire === 1'b1) act_ret++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = sample();
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL outputs %s cycle %0d: got=%07h exp=%07h (state got %0d exp %0d)",
                        tag, cyc_idx, a, e, a.state, e.state);
            end
            cyc_idx++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] ops [10];
      logic [5:0] op;
      logic [5:0] fn;
      int k;
      ops = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
              6'b000101, 6'b001000, 6'b001010, 6'b000010, 6'b000011};
      reset = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back(blank(0));
      @(posedge clk); #1;
      reset = 1'b0;

      ready_all();
      run_instr("add", 6'b000000, 6'b100000, -1);
      ready_all(); mr_pat[3] = 1'b0; mr_pat[4] = 1'b0;
      run_instr("lw_stall", 6'b100011, 6'b010101, -1);
      ready_all();
      run_instr("bne", 6'b000101, 6'b000000, -1);
      ready_all();
      run_instr("jal", 6'b000011, 6'b111111, -1);
      ready_all(); mr_pat[0] = 1'b0;
      run_instr("beq_fstall", 6'b000100, 6'b000000, -1);
      ready_all(); mr_pat[3] = 1'b0; mr_pat[4] = 1'b0; mr_pat[5] = 1'b0;
      run_instr("sw_reset", 6'b101011, 6'b000000, 4);
      ready_all();
      run_instr("jr", 6'b000000, 6'b001000, -1);
      ready_all();
      run_instr("slti", 6'b001010, 6'b000000, -1);
      ready_all();
      run_instr("addi", 6'b001000, 6'b000000, -1);
      ready_all();
      run_instr("j", 6'b000010, 6'b000000, -1);
      ready_rand(); mr_pat[0] = 1'b1;
      run_instr("trap", 6'b111111, 6'b000000, 14);
      ready_all();
      run_instr("sw", 6'b101011, 6'b000000, -1);
      ready_rand();
      run_instr("trap_hole", 6'b010000, 6'b000000, 8);

      for (int i = 0; i < 80; i++) begin
         k  = $urandom_range(0, 9);
         op = ops[k];
         fn = 6'($urandom_range(0, 63));
         if (k == 1) fn = 6'b001000;
         ready_rand();
         run_instr("rand", op, fn, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1);
      end

      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got=%0d pending exp=0", exp_q.size());
      end
      total++;
      if (act_ret != exp_ret) begin
         bad++;
         $display("FAIL retire_count: got=%0d exp=%0d", act_ret, exp_ret);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
